analog_switch_seq: RTL and testbench



---
 rtl/analog_switch_seq.sv | 140 ++++++++++++++
 tb/tb_analog_switch_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/analog_switch_seq.sv
// rtl/analog_switch_seq.sv - break-before-make sequencer for the per-channel analog switch drives
module analog_switch_seq #(
    parameter int N_CH       = 4,
    parameter int BBM_CYC    = 8,
    parameter int SETTLE_CYC = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N_CH-1:0] pud_sel_i,
    input  logic [N_CH-2:0] tr_sel_i,
    input  logic [N_CH-1:0] lp_sel_i,
    input  logic            cfg_valid_i,
    output logic            cfg_ready_o,
    input  logic            force_safe_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [N_CH:0]   pud_ctr_o,
    output logic [N_CH-2:0] tr_ctr_o,
    output logic [N_CH-1:0] lph_ctr_o,
    output logic [N_CH-1:0] lpl_ctr_o
);
    localparam int MAX_CYC = (BBM_CYC > SETTLE_CYC) ? BBM_CYC : SETTLE_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] BBM_LOAD    = CNT_W'(BBM_CYC);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {IDLE, BREAK, MAKE, SETTLE, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_CH-1:0]  app_pud, app_lp, pend_pud, pend_lp;
    logic [N_CH-2:0]  app_tr, pend_tr;
    logic [N_CH-1:0]  chg_mask;
    logic [N_CH-1:0]  brk_pud, brk_lp;
    logic [N_CH-2:0]  brk_tr;
    logic             accept;
    logic             make_now;

    // A channel is "changed" if any of its switches differs from what is applied now
    assign chg_mask = (pud_sel_i ^ app_pud) | (lp_sel_i ^ app_lp) | {1'b0, tr_sel_i ^ app_tr};
    assign brk_pud  = app_pud & ~chg_mask;
    assign brk_lp   = app_lp & ~chg_mask;
    assign brk_tr   = app_tr & ~chg_mask[N_CH-2:0];

    assign accept   = cfg_valid_i & cfg_ready_o & ~force_safe_i;
    assign make_now = (state_q == BREAK) && (cnt_q == CNT_ONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    if (|chg_mask) begin
                        state_d = BREAK;
                        cnt_d   = BBM_LOAD;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            BREAK: begin
                if (cnt_q == CNT_ONE) state_d = MAKE;
                else                  cnt_d   = cnt_q - CNT_ONE;
            end
            MAKE: begin
                state_d = SETTLE;
                cnt_d   = SETTLE_LOAD;
            end
            SETTLE: begin
                if (cnt_q == CNT_ONE) state_d = DONE;
                else                  cnt_d   = cnt_q - CNT_ONE;
            end
            default: state_d = IDLE;
        endcase
        if (force_safe_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            app_pud     <= '0;
            app_tr      <= '0;
            app_lp      <= '0;
            pend_pud    <= '0;
            pend_tr     <= '0;
            pend_lp     <= '0;
            cfg_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            pud_ctr_o   <= '0;
            tr_ctr_o    <= '0;
            lph_ctr_o   <= '0;
            lpl_ctr_o   <= '1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cfg_ready_o <= ~force_safe_i & ((state_d == IDLE) || (state_d == DONE));
            busy_o      <= state_d inside {BREAK, MAKE, SETTLE};
            done_o      <= (state_d == DONE);
            if (force_safe_i) begin
                app_pud   <= '0;
                app_tr    <= '0;
                app_lp    <= '0;
                pend_pud  <= '0;
                pend_tr   <= '0;
                pend_lp   <= '0;
                pud_ctr_o <= '0;
                tr_ctr_o  <= '0;
                lph_ctr_o <= '0;
                lpl_ctr_o <= '1;
            end else if (accept) begin
                pend_pud <= pud_sel_i;
                pend_tr  <= tr_sel_i;
                pend_lp  <= lp_sel_i;
                // Changed channels open to safe; unchanged ones keep their applied drive
                if (|chg_mask) begin
                    pud_ctr_o <= {brk_pud[N_CH-1], brk_pud};
                    tr_ctr_o  <= brk_tr;
                    lph_ctr_o <= brk_lp;
                    lpl_ctr_o <= ~brk_lp;
                end
            end else if (make_now) begin
                app_pud   <= pend_pud;
                app_tr    <= pend_tr;
                app_lp    <= pend_lp;
                pud_ctr_o <= {pend_pud[N_CH-1], pend_pud};
                tr_ctr_o  <= pend_tr;
                lph_ctr_o <= pend_lp;
                lpl_ctr_o <= ~pend_lp;
            end
        end
    end
endmodule

// File: tb/tb_analog_switch_seq.sv
// tb/tb_analog_switch_seq.sv - randomized scoreboard bench for analog_switch_seq
module tb_analog_switch_seq;
    localparam int N_CH       = 4;
    localparam int BBM_CYC    = 8;
    localparam int SETTLE_CYC = 64;
    localparam int TRW        = N_CH - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [N_CH-1:0] pud_sel;
    logic [N_CH-2:0] tr_sel;
    logic [N_CH-1:0] lp_sel;
    logic            cfg_valid;
    logic            cfg_ready;
    logic            force_safe;
    logic            busy;
    logic            done;
    logic [N_CH:0]   pud_ctr;
    logic [N_CH-2:0] tr_ctr;
    logic [N_CH-1:0] lph_ctr;
    logic [N_CH-1:0] lpl_ctr;

    analog_switch_seq #(.N_CH(N_CH), .BBM_CYC(BBM_CYC), .SETTLE_CYC(SETTLE_CYC)) dut (
        .clk_i(clk), .rst_i(rst),
        .pud_sel_i(pud_sel), .tr_sel_i(tr_sel), .lp_sel_i(lp_sel),
        .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
        .force_safe_i(force_safe), .busy_o(busy), .done_o(done),
        .pud_ctr_o(pud_ctr), .tr_ctr_o(tr_ctr), .lph_ctr_o(lph_ctr), .lpl_ctr_o(lpl_ctr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit              safe_chk;
        int              t;
        int              done_cyc;
        logic            exp_ready;
        logic [N_CH-1:0] mask;
        logic [N_CH:0]   b_pud, f_pud;
        logic [N_CH-2:0] b_tr, f_tr;
        logic [N_CH-1:0] b_lp, f_lp;
    } ent_t;

    ent_t sbq[$];
    ent_t cur;
    int   n_cmp = 0;
    int   n_bad = 0;

    int              next_ready;
    logic [N_CH-1:0] m_pud, m_lp;
    logic [N_CH-2:0] m_tr;
    logic [N_CH-1:0] last_mask;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [N_CH:0] p,
                            input logic [N_CH-2:0] t, input logic [N_CH-1:0] l);
        logic [N_CH-1:0] nl;
        nl = ~l;
        chk({tag, "_pud"}, 32'(pud_ctr), 32'(p));
        chk({tag, "_tr"},  32'(tr_ctr),  32'(t));
        chk({tag, "_lph"}, 32'(lph_ctr), 32'(l));
        chk({tag, "_lpl"}, 32'(lpl_ctr), 32'(nl));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (sbq.size() == 0) begin
                if (done) chk("spurious_done", 32'(done), 32'(0));
            end else if (sbq[0].safe_chk) begin
                if (cyc == sbq[0].t) begin
                    chk_outs("safe", '0, '0, '0);
                    chk("safe_busy", 32'(busy), 32'(0));
                    chk("safe_done", 32'(done), 32'(0));
                    chk("safe_ready", 32'(cfg_ready), 32'(sbq[0].exp_ready));
                    void'(sbq.pop_front());
                end else if (done) begin
                    chk("done_after_abort", 32'(done), 32'(0));
                end
            end else begin
                cur = sbq[0];
                if (cur.mask != 0 && (cyc == cur.t + 1 || cyc == cur.t + BBM_CYC)) begin
                    chk_outs("break", cur.b_pud, cur.b_tr, cur.b_lp);
                    chk("break_busy", 32'(busy), 32'(1));
                    chk("break_ready", 32'(cfg_ready), 32'(0));
                end
                if (cur.mask != 0 && cyc == cur.t + 1 + BBM_CYC)
                    chk_outs("make", cur.f_pud, cur.f_tr, cur.f_lp);
                if (done || cyc == cur.done_cyc) begin
                    chk("done_pulse", 32'(done), 32'(1));
                    chk("done_cycle", 32'(cyc), 32'(cur.done_cyc));
                    chk_outs("final", cur.f_pud, cur.f_tr, cur.f_lp);
                    chk("done_busy", 32'(busy), 32'(0));
                    chk("done_ready", 32'(cfg_ready), 32'(1));
                    void'(sbq.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N_CH-1:0] p, input logic [N_CH-2:0] t, input logic [N_CH-1:0] l);
        pud_sel   = p;
        tr_sel    = t;
        lp_sel    = l;
        cfg_valid = 1'b1;
    endtask

    task automatic wait_ready(input int gap);
        while (cyc < next_ready) tick();
        repeat (gap) tick();
    endtask

    task automatic push_safe(input int t, input logic rdy);
        ent_t e;
        e = '{default: '0};
        e.safe_chk  = 1'b1;
        e.t         = t;
        e.exp_ready = rdy;
        sbq.push_back(e);
    endtask

    // Reference: a request accepted in this cycle, judged against the model's applied set
    task automatic model_accept();
        ent_t e;
        e = '{default: '0};
        e.t = cyc;
        for (int k = 0; k < N_CH; k++)
            e.mask[k] = (pud_sel[k] !== m_pud[k]) || (lp_sel[k] !== m_lp[k]);
        for (int k = 0; k < N_CH - 1; k++)
            if (tr_sel[k] !== m_tr[k]) e.mask[k] = 1'b1;
        for (int k = 0; k < N_CH; k++) begin
            e.b_pud[k] = e.mask[k] ? 1'b0 : m_pud[k];
            e.b_lp[k]  = e.mask[k] ? 1'b0 : m_lp[k];
        end
        for (int k = 0; k < N_CH - 1; k++)
            e.b_tr[k] = e.mask[k] ? 1'b0 : m_tr[k];
        e.b_pud[N_CH] = e.b_pud[N_CH-1];
        e.f_pud    = {pud_sel[N_CH-1], pud_sel};
        e.f_tr     = tr_sel;
        e.f_lp     = lp_sel;
        e.done_cyc = (e.mask != 0) ? cyc + 2 + BBM_CYC + SETTLE_CYC : cyc + 1;
        next_ready = e.done_cyc;
        m_pud      = pud_sel;
        m_tr       = tr_sel;
        m_lp       = lp_sel;
        last_mask  = e.mask;
        sbq.push_back(e);
    endtask

    task automatic abort_at(input int f);
        cfg_valid = 1'b0;
        while (cyc < f) tick();
        force_safe = 1'b1;
        sbq.delete();
        push_safe(f + 1, 1'b0);
        m_pud = '0;
        m_tr  = '0;
        m_lp  = '0;
        next_ready = f + 2;
        tick();
        force_safe = 1'b0;
    endtask

    task automatic gen_cfg(output logic [N_CH-1:0] p, output logic [N_CH-2:0] t, output logic [N_CH-1:0] l);
        int mode;
        int b;
        p = m_pud;
        t = m_tr;
        l = m_lp;
        mode = $urandom_range(0, 3);
        if (mode == 1) begin
            b = $urandom_range(0, 3 * N_CH - 2);
            if (b < N_CH)          p[b] = ~p[b];
            else if (b < 2 * N_CH) l[b - N_CH] = ~l[b - N_CH];
            else                   t[b - 2 * N_CH] = ~t[b - 2 * N_CH];
        end else if (mode >= 2) begin
            p = N_CH'($urandom);
            t = TRW'($urandom);
            l = N_CH'($urandom);
        end
    endtask

    initial begin
        logic [N_CH-1:0] p, l;
        logic [N_CH-2:0] t;
        bit hold;
        int r;
        rst = 1'b1; cfg_valid = 1'b0; force_safe = 1'b0;
        pud_sel = '0; tr_sel = '0; lp_sel = '0;
        m_pud = '0; m_tr = '0; m_lp = '0; last_mask = '0;
        hold = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        push_safe(cyc, 1'b1);
        next_ready = cyc + 1;

        wait_ready(0); drive(4'b1000, 3'b001, 4'b0101); model_accept(); tick(); cfg_valid = 1'b0;
        wait_ready(1); drive(4'b1000, 3'b001, 4'b0100); model_accept(); tick(); cfg_valid = 1'b0;
        wait_ready(0); drive(4'b1000, 3'b001, 4'b0100); model_accept(); tick(); cfg_valid = 1'b0;
        wait_ready(2); drive(4'b0110, 3'b110, 4'b0011); model_accept(); tick();
        abort_at(next_ready - 30);
        wait_ready(0); drive(4'b0001, 3'b000, 4'b0000); model_accept(); tick();
        drive(4'b0010, 3'b011, 4'b1100);
        wait_ready(0); model_accept(); tick(); cfg_valid = 1'b0;

        for (int i = 0; i < 30; i++) begin
            if (!hold) begin
                gen_cfg(p, t, l);
                wait_ready($urandom_range(0, 3));
                drive(p, t, l);
            end else begin
                wait_ready(0);
            end
            model_accept();
            tick();
            r = $urandom_range(0, 5);
            if (r == 0 && last_mask != 0) begin
                abort_at($urandom_range(cyc, next_ready - 1));
                hold = 1'b0;
            end else if (r <= 2) begin
                gen_cfg(p, t, l);
                drive(p, t, l);
                hold = 1'b1;
            end else begin
                cfg_valid = 1'b0;
                hold = 1'b0;
            end
        end
        cfg_valid = 1'b0;
        for (int i = 0; i < 400 && sbq.size() > 0; i++) tick();
        tick();
        chk("queue_drained", 32'(sbq.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
